fwd_select_unit: RTL and testbench
==================================

# fwd_select_unit

Pipeline forwarding and load-use hazard controller for the RICS integer pipeline. It tracks destination-register tags of in-flight instructions, produces the registered 2-bit operand-source codes (0 = register file, 1 = EX/MEM result, 2 = MEM/WB result) consumed by the downstream operand-select decoder, and asserts a one-cycle stall on load-use hazards. It sits in the ID→EX boundary and feeds the EX-stage operand multiplexer controls.

## Interface
- `REG_ADDR_W`, default 5: register-address width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inp_valid`  in  1  ID-stage instruction valid.
- `inp_rs1`, `inp_rs2`  in  REG_ADDR_W each  ID source register addresses.
- `inp_rd`  in  REG_ADDR_W  ID destination register.
- `inp_wr_en`  in  1  ID instruction writes `inp_rd`.
- `inp_is_load`  in  1  ID instruction is a load.
- `inp_hold`  in  1  global pipeline freeze (memory wait).
- `out_fwd_a`, `out_fwd_b`  out  2 each  EX-stage source code for operand A/B.
- `out_stall`  out  1  hold PC and IF/ID; insert bubble.
- `out_stall_cnt`  out  16  stall counter (only with macro, see Configuration).

## Operation
- Internal tag stages, each {valid, wr_en, is_load, rd}: `t_ex` (ID/EX), `t_mem` (EX/MEM), `t_wb` (MEM/WB).
- Each non-held edge: `t_wb`←`t_mem`, `t_mem`←`t_ex`, `t_ex`←ID fields, or a bubble (valid=0) when `out_stall`=1.
- Match(t, rs): t.valid & t.wr_en & t.rd==rs & rs≠0. Register 0 never forwards.
- Next code per operand: 1 if Match(`t_ex`, rs); else 2 if Match(`t_mem`, rs); else 0. Nearer stage has priority. Registered into `out_fwd_a/b` on the same edge `t_ex` loads; bubble ⇒ code 0.
- Hazard: `inp_valid` & `t_ex`.is_load & (Match(`t_ex`, rs1) | Match(`t_ex`, rs2)).
- FSM states RUN, STALL:
  - RUN: `out_stall` = hazard (combinational). Hazard & !`inp_hold` → STALL.
  - STALL: `out_stall`=0; next non-held edge → RUN. Guarantees at most one stall cycle per hazard; after it the load is in `t_mem` and the dependant receives code 2.
- Code 3 is never produced.

## Timing
- Reset (async, immediate): all tag valids 0, `out_fwd_a`=`out_fwd_b`=0, FSM=RUN, `out_stall`=0, `out_stall_cnt`=0.
- Latency: ID fields at edge N ⇒ codes valid for the EX cycle following edge N.
- `out_stall` combinational from ID inputs and `t_ex`; stable before the edge.
- `inp_hold`=1: tags, codes, FSM and counter all hold; `out_stall` still reflects hazard. Hold dominates stall.
- Hazard on both operands: single stall, both resolve to 2.
- Reset mid-stall: returns to RUN, pipeline tags cleared, no residual stall.
- `inp_valid`=0: no hazard; tag loads with valid=0.

## Configuration
- `FWD_SELECT_STALL_CNT_EN` defined: `out_stall_cnt` present, incremented on each non-held edge with `out_stall`=1, saturating at 16'hFFFF, reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package: `FWD_SRC_RF`=2'd0, `FWD_SRC_EXMEM`=2'd1, `FWD_SRC_MEMWB`=2'd2, tag-stage struct/field widths.
- One sub-module `fwd_src_cmp`: two tag stages + rs → 2-bit code; instantiated per operand.

## Test plan
- Back-to-back ALU: I1 rd=3 wr; I2 rs1=3 → I2 in EX sees `out_fwd_a`=1, `out_stall`=0.
- Distance two: I1 rd=4, filler, I3 rs2=4 → `out_fwd_b`=2.
- Both stages match rd=5, rs1=5 → code 1 (priority); rs1=0 with rd=0 writers → code 0.
- Load-use: load rd=6; next rs1=6,rs2=6 → `out_stall`=1 for exactly one cycle, bubble, then both codes 2; counter 1 if enabled.
- `inp_hold` asserted 3 cycles during pending hazard → state/codes frozen, stall taken once after release.
- Async `rst` asserted while in STALL → outputs 0 immediately, FSM=RUN; subsequent independent instruction yields codes 0.

Source files
------------

// File: rtl/fwd_select_unit_pkg.sv
// -----------------------------------------------------------------------------
// fwd_select_unit_pkg
// Shared definitions for the forwarding / load-use hazard controller:
//   - operand-source codes driven to the EX-stage operand-select decoder
//   - hazard FSM state encoding
//   - default register-address width and stall-counter width
//   - saturating increment helper for the optional stall counter
// -----------------------------------------------------------------------------
package fwd_select_unit_pkg;

    // Operand-source codes (code 3 is never generated)
    localparam int         FWD_CODE_W    = 2;
    localparam logic [1:0] FWD_SRC_RF    = 2'd0;
    localparam logic [1:0] FWD_SRC_EXMEM = 2'd1;
    localparam logic [1:0] FWD_SRC_MEMWB = 2'd2;

    // Default register-address width of the RICS integer pipeline
    localparam int FWD_REG_ADDR_W = 5;

    // Tag-stage control-field width: {valid, wr_en, is_load}
    localparam int FWD_TAG_CTRL_W = 3;

    // Optional stall counter
    localparam int          FWD_STALL_CNT_W   = 16;
    localparam logic [15:0] FWD_STALL_CNT_MAX = 16'hFFFF;

    // Hazard controller states
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fwd_state_e;

    // Saturating increment for the stall counter
    function automatic logic [FWD_STALL_CNT_W-1:0] stall_cnt_inc(
        input logic [FWD_STALL_CNT_W-1:0] cnt
    );
        logic [FWD_STALL_CNT_W-1:0] res;
        if (cnt == FWD_STALL_CNT_MAX) begin
            res = cnt;
        end else begin
            res = cnt + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fwd_select_unit_fwd_src_cmp.sv
// -----------------------------------------------------------------------------
// fwd_src_cmp
// Resolves the EX-stage source of one operand from the two youngest in-flight
// tag stages. The stage nearer to EX wins; register 0 never forwards.
// Ports:
//   ex_valid_i/ex_wr_en_i/ex_rd_i    tag currently in ID/EX
//   mem_valid_i/mem_wr_en_i/mem_rd_i tag currently in EX/MEM
//   rs_i                             source register of the ID instruction
//   code_o                           next operand-source code (0/1/2)
//   ex_match_o                       ID/EX tag writes rs_i (used for load-use)
// -----------------------------------------------------------------------------
module fwd_src_cmp
    import fwd_select_unit_pkg::*;
#(
    parameter int REG_ADDR_W = FWD_REG_ADDR_W
) (
    input  logic                  ex_valid_i,
    input  logic                  ex_wr_en_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  mem_valid_i,
    input  logic                  mem_wr_en_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    output logic [FWD_CODE_W-1:0] code_o,
    output logic                  ex_match_o
);

    logic rs_nz_s;
    logic mem_match_s;

    // Tag comparison and nearest-stage priority selection
    always_comb begin
        rs_nz_s     = (rs_i != {REG_ADDR_W{1'b0}});
        ex_match_o  = ex_valid_i & ex_wr_en_i & (ex_rd_i == rs_i) & rs_nz_s;
        mem_match_s = mem_valid_i & mem_wr_en_i & (mem_rd_i == rs_i) & rs_nz_s;
        code_o      = FWD_SRC_RF;
        if (ex_match_o) begin
            code_o = FWD_SRC_EXMEM;
        end else if (mem_match_s) begin
            code_o = FWD_SRC_MEMWB;
        end else begin
            code_o = FWD_SRC_RF;
        end
    end

endmodule

// File: rtl/fwd_select_unit.sv
// -----------------------------------------------------------------------------
// fwd_select_unit
// Forwarding and load-use hazard controller at the ID->EX boundary.
// Tracks destination tags of in-flight instructions (ID/EX, EX/MEM, MEM/WB),
// registers the 2-bit operand-source codes for the EX-stage operand mux and
// raises a single-cycle stall when an instruction consumes a load result
// that is still in EX.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   inp_valid                ID instruction valid
//   inp_rs1, inp_rs2         ID source registers
//   inp_rd, inp_wr_en        ID destination register and its write enable
//   inp_is_load              ID instruction is a load
//   inp_hold                 global pipeline freeze (dominates stall)
//   out_fwd_a, out_fwd_b     registered EX operand-source codes
//   out_stall                combinational stall request (hold PC, IF/ID)
//   out_stall_cnt            stall counter, only when FWD_SELECT_STALL_CNT_EN
//                            is defined
//
// Build option: define FWD_SELECT_STALL_CNT_EN to add the saturating
// out_stall_cnt port and counter.
// -----------------------------------------------------------------------------
module fwd_select_unit
    import fwd_select_unit_pkg::*;
#(
    parameter int REG_ADDR_W = FWD_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inp_valid,
    input  logic [REG_ADDR_W-1:0] inp_rs1,
    input  logic [REG_ADDR_W-1:0] inp_rs2,
    input  logic [REG_ADDR_W-1:0] inp_rd,
    input  logic                  inp_wr_en,
    input  logic                  inp_is_load,
    input  logic                  inp_hold,
    output logic [FWD_CODE_W-1:0] out_fwd_a,
    output logic [FWD_CODE_W-1:0] out_fwd_b,
    output logic                  out_stall
`ifdef FWD_SELECT_STALL_CNT_EN
    ,
    output logic [FWD_STALL_CNT_W-1:0] out_stall_cnt
`endif
);

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rd;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '{valid: 1'b0, wr_en: 1'b0, is_load: 1'b0,
                                    rd: {REG_ADDR_W{1'b0}}};

    tag_t                  t_ex_q,  t_ex_d;
    tag_t                  t_mem_q, t_mem_d;
    tag_t                  t_wb_q,  t_wb_d;
    fwd_state_e            state_q, state_d;
    logic [FWD_CODE_W-1:0] fwd_a_q, fwd_a_d;
    logic [FWD_CODE_W-1:0] fwd_b_q, fwd_b_d;

    logic [FWD_CODE_W-1:0] code_a_s;
    logic [FWD_CODE_W-1:0] code_b_s;
    logic                  ex_match_a_s;
    logic                  ex_match_b_s;
    logic                  hazard_s;
    logic                  stall_s;
    logic                  bubble_s;

    // The MEM/WB tag completes the in-flight history but no operand selects
    // from it; its bits are only folded here so they stay visible.
    logic unused_tag_bits_s;
    assign unused_tag_bits_s = ^{t_wb_q, t_mem_q.is_load};

    fwd_src_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_a (
        .ex_valid_i  (t_ex_q.valid),
        .ex_wr_en_i  (t_ex_q.wr_en),
        .ex_rd_i     (t_ex_q.rd),
        .mem_valid_i (t_mem_q.valid),
        .mem_wr_en_i (t_mem_q.wr_en),
        .mem_rd_i    (t_mem_q.rd),
        .rs_i        (inp_rs1),
        .code_o      (code_a_s),
        .ex_match_o  (ex_match_a_s)
    );

    fwd_src_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_b (
        .ex_valid_i  (t_ex_q.valid),
        .ex_wr_en_i  (t_ex_q.wr_en),
        .ex_rd_i     (t_ex_q.rd),
        .mem_valid_i (t_mem_q.valid),
        .mem_wr_en_i (t_mem_q.wr_en),
        .mem_rd_i    (t_mem_q.rd),
        .rs_i        (inp_rs2),
        .code_o      (code_b_s),
        .ex_match_o  (ex_match_b_s)
    );

    // Load-use hazard detection: the load in EX has no result until MEM
    always_comb begin
        hazard_s = inp_valid & t_ex_q.is_load & (ex_match_a_s | ex_match_b_s);
    end

    // Hazard FSM: STALL state suppresses a second stall for the same hazard
    always_comb begin
        state_d = state_q;
        stall_s = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                stall_s = hazard_s;
                if (hazard_s && !inp_hold) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: begin
                stall_s = 1'b0;
                if (inp_hold) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                stall_s = 1'b0;
                state_d = ST_RUN;
            end
        endcase
    end

    // Next tag stages and operand codes; hold freezes everything
    always_comb begin
        bubble_s = stall_s | ~inp_valid;
        t_ex_d   = t_ex_q;
        t_mem_d  = t_mem_q;
        t_wb_d   = t_wb_q;
        fwd_a_d  = fwd_a_q;
        fwd_b_d  = fwd_b_q;
        if (!inp_hold) begin
            t_wb_d  = t_mem_q;
            t_mem_d = t_ex_q;
            if (bubble_s) begin
                t_ex_d  = TAG_BUBBLE;
                fwd_a_d = FWD_SRC_RF;
                fwd_b_d = FWD_SRC_RF;
            end else begin
                t_ex_d.valid   = 1'b1;
                t_ex_d.wr_en   = inp_wr_en;
                t_ex_d.is_load = inp_is_load;
                t_ex_d.rd      = inp_rd;
                fwd_a_d        = code_a_s;
                fwd_b_d        = code_b_s;
            end
        end else begin
            t_ex_d  = t_ex_q;
            t_mem_d = t_mem_q;
            t_wb_d  = t_wb_q;
        end
    end

    // Tag pipeline, operand codes and FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_ex_q  <= TAG_BUBBLE;
            t_mem_q <= TAG_BUBBLE;
            t_wb_q  <= TAG_BUBBLE;
            fwd_a_q <= FWD_SRC_RF;
            fwd_b_q <= FWD_SRC_RF;
            state_q <= ST_RUN;
        end else begin
            t_ex_q  <= t_ex_d;
            t_mem_q <= t_mem_d;
            t_wb_q  <= t_wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            state_q <= state_d;
        end
    end

    assign out_fwd_a = fwd_a_q;
    assign out_fwd_b = fwd_b_q;
    assign out_stall = stall_s;

`ifdef FWD_SELECT_STALL_CNT_EN
    logic [FWD_STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Stall counter next value: counts stall cycles that actually advance
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!inp_hold && stall_s) begin
            stall_cnt_d = stall_cnt_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {FWD_STALL_CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_select_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_select_unit
// Self-checking bench. The reference model keeps the list of the two most
// recent instructions that entered EX and derives operand codes from their
// issue distance, and stall from "the instruction just issued is a load I
// read" plus a flag that the previous advancing cycle already stalled.
// -----------------------------------------------------------------------------
module tb_fwd_select_unit;

    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          inp_valid;
    logic [AW-1:0] inp_rs1;
    logic [AW-1:0] inp_rs2;
    logic [AW-1:0] inp_rd;
    logic          inp_wr_en;
    logic          inp_is_load;
    logic          inp_hold;
    logic [1:0]    out_fwd_a;
    logic [1:0]    out_fwd_b;
    logic          out_stall;
`ifdef FWD_SELECT_STALL_CNT_EN
    logic [15:0]   out_stall_cnt;
`endif

    fwd_select_unit #(.REG_ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .inp_valid   (inp_valid),
        .inp_rs1     (inp_rs1),
        .inp_rs2     (inp_rs2),
        .inp_rd      (inp_rd),
        .inp_wr_en   (inp_wr_en),
        .inp_is_load (inp_is_load),
        .inp_hold    (inp_hold),
        .out_fwd_a   (out_fwd_a),
        .out_fwd_b   (out_fwd_b),
        .out_stall   (out_stall)
`ifdef FWD_SELECT_STALL_CNT_EN
        ,
        .out_stall_cnt (out_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit wr;
        bit ld;
        int rd;
    } instr_t;

    instr_t     iss [2];   // iss[0] = most recently issued into EX, iss[1] = one before
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    int         exp_cnt;
    bit         just_stalled;
    int         checks;
    int         errors;

    function automatic logic [1:0] m_code(input int rs);
        if (rs == 0) return 2'd0;
        for (int d = 0; d < 2; d++) begin
            if (iss[d].v && iss[d].wr && iss[d].rd == rs) return 2'(d + 1);
        end
        return 2'd0;
    endfunction

    function automatic bit m_stall();
        bit uses_load;
        uses_load = iss[0].v && iss[0].wr && iss[0].ld &&
                    ((inp_rs1 != 0 && int'(inp_rs1) == iss[0].rd) ||
                     (inp_rs2 != 0 && int'(inp_rs2) == iss[0].rd));
        return inp_valid && uses_load && !just_stalled;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) iss[i] = '{0, 0, 0, 0};
        exp_a        = 2'd0;
        exp_b        = 2'd0;
        exp_cnt      = 0;
        just_stalled = 1'b0;
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit wr, input bit ld, input bit hold);
        inp_valid   = v;
        inp_rs1     = AW'(rs1);
        inp_rs2     = AW'(rs2);
        inp_rd      = AW'(rd);
        inp_wr_en   = wr;
        inp_is_load = ld;
        inp_hold    = hold;
        #2;
    endtask

    // Advance one clock and update the model with what the edge consumed
    task automatic tick();
        bit         s;
        bit         v;
        bit         h;
        logic [1:0] a;
        logic [1:0] b;
        instr_t     cur;
        s   = m_stall();
        a   = m_code(int'(inp_rs1));
        b   = m_code(int'(inp_rs2));
        v   = inp_valid;
        h   = inp_hold;
        cur = '{1, inp_wr_en, inp_is_load, int'(inp_rd)};
        @(posedge clk);
        #1;
        if (!h) begin
            iss[1] = iss[0];
            if (s || !v) begin
                iss[0] = '{0, 0, 0, 0};
                exp_a  = 2'd0;
                exp_b  = 2'd0;
            end else begin
                iss[0] = cur;
                exp_a  = a;
                exp_b  = b;
            end
            if (s && exp_cnt < 65535) exp_cnt++;
            just_stalled = s;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        // a load followed by a dependant, then reset with the hazard pending
        drive(1, 0, 0, 6, 1, 1, 0);
        tick();
        drive(1, 6, 0, 1, 1, 0, 0);
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", out_stall); end
        checks++; if (out_fwd_a !== 2'd0) begin errors++; $display("FAIL reset_fwd_a: got %0d expected 0", out_fwd_a); end
        checks++; if (out_fwd_b !== 2'd0) begin errors++; $display("FAIL reset_fwd_b: got %0d expected 0", out_fwd_b); end
`ifdef FWD_SELECT_STALL_CNT_EN
        checks++; if (out_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", out_stall_cnt); end
`endif
        do_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 3, 0, 9, 1, 0, 0);
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %0d expected 0", out_stall); end
        tick();
        checks++; if (out_fwd_a !== 2'd1) begin errors++; $display("FAIL b2b_fwd_a: got %0d expected 1", out_fwd_a); end
        checks++; if (out_fwd_b !== 2'd0) begin errors++; $display("FAIL b2b_fwd_b: got %0d expected 0", out_fwd_b); end
    endtask

    task automatic test_distance_two();
        do_reset();
        drive(1, 0, 0, 4, 1, 0, 0);
        tick();
        drive(1, 1, 2, 10, 1, 0, 0);
        tick();
        drive(1, 0, 4, 11, 1, 0, 0);
        tick();
        checks++; if (out_fwd_b !== 2'd2) begin errors++; $display("FAIL dist2_fwd_b: got %0d expected 2", out_fwd_b); end
        checks++; if (out_fwd_a !== 2'd0) begin errors++; $display("FAIL dist2_fwd_a: got %0d expected 0", out_fwd_a); end
    endtask

    task automatic test_priority();
        do_reset();
        drive(1, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 5, 5, 12, 1, 0, 0);
        tick();
        checks++; if (out_fwd_a !== 2'd1) begin errors++; $display("FAIL prio_fwd_a: got %0d expected 1", out_fwd_a); end
        checks++; if (out_fwd_b !== 2'd1) begin errors++; $display("FAIL prio_fwd_b: got %0d expected 1", out_fwd_b); end
        // writers to r0 never forward
        drive(1, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 1, 0);
        tick();
        drive(1, 0, 0, 13, 1, 0, 0);
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %0d expected 0", out_stall); end
        tick();
        checks++; if (out_fwd_a !== 2'd0) begin errors++; $display("FAIL r0_fwd_a: got %0d expected 0", out_fwd_a); end
        checks++; if (out_fwd_b !== 2'd0) begin errors++; $display("FAIL r0_fwd_b: got %0d expected 0", out_fwd_b); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 6, 1, 1, 0);
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL lu_pre_stall: got %0d expected 0", out_stall); end
        tick();
        drive(1, 6, 6, 7, 1, 0, 0);
        checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0d expected 1", out_stall); end
        tick();
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %0d expected 0", out_stall); end
        checks++; if (out_fwd_a !== 2'd0) begin errors++; $display("FAIL lu_bubble_a: got %0d expected 0", out_fwd_a); end
        tick();
        checks++; if (out_fwd_a !== 2'd2) begin errors++; $display("FAIL lu_fwd_a: got %0d expected 2", out_fwd_a); end
        checks++; if (out_fwd_b !== 2'd2) begin errors++; $display("FAIL lu_fwd_b: got %0d expected 2", out_fwd_b); end
`ifdef FWD_SELECT_STALL_CNT_EN
        checks++; if (out_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", out_stall_cnt); end
`endif
    endtask

    task automatic test_hold();
        logic [1:0] a0;
        logic [1:0] b0;
        do_reset();
        drive(1, 0, 0, 8, 1, 1, 0);
        tick();
        a0 = out_fwd_a;
        b0 = out_fwd_b;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8, 0, 14, 1, 0, 1);
            checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d]: got %0d expected 1", i, out_stall); end
            tick();
            checks++; if (out_fwd_a !== a0 || out_fwd_b !== b0) begin
                errors++; $display("FAIL hold_frozen[%0d]: got %0d/%0d expected %0d/%0d", i, out_fwd_a, out_fwd_b, a0, b0);
            end
        end
        drive(1, 8, 0, 14, 1, 0, 0);
        checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall: got %0d expected 1", out_stall); end
        tick();
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL hold_single_stall: got %0d expected 0", out_stall); end
        tick();
        checks++; if (out_fwd_a !== 2'd2) begin errors++; $display("FAIL hold_fwd_a: got %0d expected 2", out_fwd_a); end
`ifdef FWD_SELECT_STALL_CNT_EN
        checks++; if (out_stall_cnt !== 16'd1) begin errors++; $display("FAIL hold_cnt: got %0d expected 1", out_stall_cnt); end
`endif
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 0, 0, 9, 1, 1, 0);
        tick();
        drive(1, 9, 0, 15, 1, 0, 0);
        tick();                         // now in STALL, bubble in EX
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (out_stall !== 1'b0 || out_fwd_a !== 2'd0 || out_fwd_b !== 2'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got %0d/%0d/%0d expected 0/0/0", out_stall, out_fwd_a, out_fwd_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 9, 9, 16, 1, 0, 0);
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_no_stall: got %0d expected 0", out_stall); end
        tick();
        checks++; if (out_fwd_a !== 2'd0 || out_fwd_b !== 2'd0) begin
            errors++; $display("FAIL rst_mid_codes: got %0d/%0d expected 0/0", out_fwd_a, out_fwd_b);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0));
            checks++; if (out_stall !== m_stall()) begin
                errors++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", i, out_stall, m_stall());
            end
            tick();
            checks++; if (out_fwd_a !== exp_a || out_fwd_b !== exp_b) begin
                errors++; $display("FAIL rnd_codes[%0d]: got %0d/%0d expected %0d/%0d", i, out_fwd_a, out_fwd_b, exp_a, exp_b);
            end
`ifdef FWD_SELECT_STALL_CNT_EN
            checks++; if (out_stall_cnt !== 16'(exp_cnt)) begin
                errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, out_stall_cnt, exp_cnt);
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_back_to_back();
        test_distance_two();
        test_priority();
        test_load_use();
        test_hold();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
